// File: rtl/pipe_control_pkg.sv
// Shared definitions for the mips32 pipeline control: control-word bit
// positions, opcode/func codes, the decode table and the stall FSM states.
package mips_ctrl_pkg;

  localparam int unsigned CTRL_W = 8;

  localparam int unsigned CB_ALU_SRC   = 7;
  localparam int unsigned CB_REG_DEST  = 5;  // two bits: [6:5]
  localparam int unsigned CB_MEM_READ  = 4;
  localparam int unsigned CB_MEM_WRITE = 3;
  localparam int unsigned CB_REG_WRITE = 2;
  localparam int unsigned CB_REG_SRC   = 0;  // two bits: [1:0]

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] SRC_PC_IMM = 2'd0;
  localparam logic [1:0] SRC_IMM26  = 2'd1;
  localparam logic [1:0] SRC_REG    = 2'd2;

  localparam logic [1:0] CMP_NONE   = 2'd0;
  localparam logic [1:0] CMP_BEQ    = 2'd1;
  localparam logic [1:0] CMP_BNE    = 2'd2;
  localparam logic [1:0] CMP_ALWAYS = 2'd3;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] word;
    logic [1:0]        src;
    logic [1:0]        code;
  } decode_t;

  function automatic decode_t decode(input logic [5:0] opcode, input logic [5:0] func);
    decode_t d;
    d = '0;
    case (opcode)
      OP_RTYPE: begin
        if (func == FN_JR) begin
          d.src  = SRC_REG;
          d.code = CMP_ALWAYS;
        end else begin
          d.word = 8'h21;
        end
      end
      OP_J:    begin d.src = SRC_IMM26; d.code = CMP_ALWAYS; end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: d.word = 8'h22;
      OP_BEQ:  d.code = CMP_BEQ;
      OP_BNE:  d.code = CMP_BNE;
      OP_JAL:  begin d.word = 8'h85; d.src = SRC_IMM26; d.code = CMP_ALWAYS; end
      OP_LW:   d.word = 8'hD6;
      OP_SW:   d.word = 8'h88;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipe_control_if.sv
// ID-stage decode inputs and pipeline control outputs of pipe_control.
interface pipe_control_if #(
  parameter int unsigned CONTROL_SIZE = 8,
  parameter int unsigned REG_ADDR_W   = 5
) ();
  logic [5:0]              opcode_id;
  logic [5:0]              func_id;
  logic [REG_ADDR_W-1:0]   rs_id;
  logic [REG_ADDR_W-1:0]   rt_id;
  logic [REG_ADDR_W-1:0]   rd_id;
  logic                    branch_eq;
  logic [1:0]              branch_src_id;
  logic [1:0]              compare_code_id;
  logic [CONTROL_SIZE-1:0] ctrl_ex;
  logic [1:0]              ctrl_mem;
  logic [2:0]              ctrl_wb;
  logic [REG_ADDR_W-1:0]   dest_ex;
  logic [REG_ADDR_W-1:0]   dest_mem;
  logic [REG_ADDR_W-1:0]   dest_wb;
  logic                    pc_write;
  logic                    ifid_write;
  logic                    ifid_flush;

  modport master (
    output opcode_id, func_id, rs_id, rt_id, rd_id, branch_eq,
    input  branch_src_id, compare_code_id, ctrl_ex, ctrl_mem, ctrl_wb,
           dest_ex, dest_mem, dest_wb, pc_write, ifid_write, ifid_flush
  );

  modport slave (
    input  opcode_id, func_id, rs_id, rt_id, rd_id, branch_eq,
    output branch_src_id, compare_code_id, ctrl_ex, ctrl_mem, ctrl_wb,
           dest_ex, dest_mem, dest_wb, pc_write, ifid_write, ifid_flush
  );
endinterface

// File: rtl/pipe_control_decode.sv
// Combinational opcode/func decoder producing the control word and branch info.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  output logic [CTRL_W-1:0] word,
  output logic [1:0]        branch_src,
  output logic [1:0]        compare_code
);
  decode_t dec;

  always_comb begin
    dec          = decode(opcode, func);
    word         = dec.word;
    branch_src   = dec.src;
    compare_code = dec.code;
  end
endmodule

// File: rtl/pipe_control.sv
// Pipeline control: decode, ID/EX/MEM/WB control registers, load-use stall
// FSM and IF/ID flush on taken branches/jumps.
module pipe_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CONTROL_SIZE = 8,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_STALL   = 1,
  parameter int unsigned RA_REG       = 31
) (
  input  logic         clock,
  input  logic         reset,
  pipe_control_if.slave bus
);
  localparam int unsigned CNT_W = 2;

  logic [CTRL_W-1:0]       word_id;
  logic [1:0]              src_id;
  logic [1:0]              code_id;
  logic [REG_ADDR_W-1:0]   dest_id;
  logic                    taken;
  logic                    hazard;
  logic                    stall;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CONTROL_SIZE-1:0] ctrl_ex_q, ctrl_ex_d;
  logic [4:0]              ctrl_mem_q, ctrl_mem_d;  // {MemRead, MemWrite, RegWrite, RegSrc}
  logic [2:0]              ctrl_wb_q, ctrl_wb_d;
  logic [REG_ADDR_W-1:0]   dest_ex_q, dest_ex_d;
  logic [REG_ADDR_W-1:0]   dest_mem_q, dest_mem_d;
  logic [REG_ADDR_W-1:0]   dest_wb_q, dest_wb_d;

  ctrl_decode u_decode (
    .opcode       (bus.opcode_id),
    .func         (bus.func_id),
    .word         (word_id),
    .branch_src   (src_id),
    .compare_code (code_id)
  );

  always_comb begin
    case (word_id[CB_REG_DEST +: 2])
      2'd0:    dest_id = bus.rd_id;
      2'd1:    dest_id = bus.rt_id;
      2'd2:    dest_id = REG_ADDR_W'(RA_REG);
      default: dest_id = '0;
    endcase

    taken = (code_id == CMP_ALWAYS)
         || ((code_id == CMP_BEQ) && bus.branch_eq)
         || ((code_id == CMP_BNE) && !bus.branch_eq);

    hazard = ctrl_ex_q[CB_MEM_READ] && ctrl_ex_q[CB_REG_WRITE] && (dest_ex_q != '0)
          && ((dest_ex_q == bus.rs_id) || (dest_ex_q == bus.rt_id));
    stall  = hazard || (state_q == STALL);

    // The detection cycle is itself the first bubble, so STALL only covers
    // the remaining LOAD_STALL-1 cycles and exits when the counter reaches 0.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (hazard && (LOAD_STALL > 1)) begin
          state_d = STALL;
          cnt_d   = CNT_W'(LOAD_STALL - 1);
        end
      end
      STALL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    ctrl_ex_d  = stall ? '0 : CONTROL_SIZE'(word_id);
    dest_ex_d  = stall ? '0 : dest_id;
    ctrl_mem_d = {ctrl_ex_q[CB_MEM_READ], ctrl_ex_q[CB_MEM_WRITE],
                  ctrl_ex_q[CB_REG_WRITE], ctrl_ex_q[CB_REG_SRC +: 2]};
    dest_mem_d = dest_ex_q;
    ctrl_wb_d  = ctrl_mem_q[2:0];
    dest_wb_d  = dest_mem_q;

    bus.branch_src_id   = src_id;
    bus.compare_code_id = code_id;
    bus.pc_write        = !reset && !stall;
    bus.ifid_write      = !reset && !stall;
    bus.ifid_flush      = !reset && !stall && taken;
    bus.ctrl_ex         = ctrl_ex_q;
    bus.ctrl_mem        = ctrl_mem_q[4:3];
    bus.ctrl_wb         = ctrl_wb_q;
    bus.dest_ex         = dest_ex_q;
    bus.dest_mem        = dest_mem_q;
    bus.dest_wb         = dest_wb_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      ctrl_ex_q  <= '0;
      ctrl_mem_q <= '0;
      ctrl_wb_q  <= '0;
      dest_ex_q  <= '0;
      dest_mem_q <= '0;
      dest_wb_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_ex_q  <= ctrl_ex_d;
      ctrl_mem_q <= ctrl_mem_d;
      ctrl_wb_q  <= ctrl_wb_d;
      dest_ex_q  <= dest_ex_d;
      dest_mem_q <= dest_mem_d;
      dest_wb_q  <= dest_wb_d;
    end
  end
endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: two instances (LOAD_STALL=1/RA=31 and
// LOAD_STALL=3/RA=2); EX-stage words are checked through a scoreboard queue.
module tb_pipe_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_control_if #(.CONTROL_SIZE(8), .REG_ADDR_W(5)) ifa ();
  pipe_control_if #(.CONTROL_SIZE(8), .REG_ADDR_W(5)) ifb ();

  pipe_control #(.CONTROL_SIZE(8), .REG_ADDR_W(5), .LOAD_STALL(1), .RA_REG(31)) dut_a (
    .clock(clk), .reset(rst), .bus(ifa));
  pipe_control #(.CONTROL_SIZE(8), .REG_ADDR_W(5), .LOAD_STALL(3), .RA_REG(2)) dut_b (
    .clock(clk), .reset(rst), .bus(ifb));

  typedef struct { logic [7:0] ctrl; logic [4:0] dest; } exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sel = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic beq);
    if (sel) begin
      ifb.opcode_id = op; ifb.func_id = fn; ifb.rs_id = rs; ifb.rt_id = rt;
      ifb.rd_id = rd; ifb.branch_eq = beq;
    end else begin
      ifa.opcode_id = op; ifa.func_id = fn; ifa.rs_id = rs; ifa.rt_id = rt;
      ifa.rd_id = rd; ifa.branch_eq = beq;
    end
    #1;
  endtask

  task automatic push_ex(input logic [7:0] c, input logic [4:0] d);
    exp_t e;
    e.ctrl = c;
    e.dest = d;
    exp_q.push_back(e);
  endtask

  // Advance one edge and compare the EX stage of the selected DUT with the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("ctrl_ex", sel ? ifb.ctrl_ex : ifa.ctrl_ex, e.ctrl);
      chk("dest_ex", sel ? ifb.dest_ex : ifa.dest_ex, e.dest);
    end
  endtask

  function automatic logic [2:0] flags();
    return sel ? {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush}
               : {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b1; set_id(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    sel = 1'b0; set_id(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);  // J held in ID during reset

    // Reset: outputs zero, no enables, no flush despite a jump in ID
    @(posedge clk); @(posedge clk); #1;
    chk("rst_flags", flags(), 3'b000);
    chk("rst_ctrl_ex", ifa.ctrl_ex, 8'h00);
    chk("rst_ctrl_wb", ifa.ctrl_wb, 3'b000);
    chk("rst_dest_wb", ifa.dest_wb, 5'd0);
    rst = 1'b0;
    set_id(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    push_ex(8'h00, 5'd0); tick();

    // LW (dest RA=31) then R-type reading $31, LOAD_STALL=1
    set_id(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    chk("lw_flags", flags(), 3'b110);
    push_ex(8'hD6, 5'd31); tick();
    set_id(6'h00, 6'h20, 5'd31, 5'd3, 5'd4, 1'b0);
    chk("hz1_flags", flags(), 3'b000);
    push_ex(8'h00, 5'd0); tick();
    chk("lw_ctrl_mem", ifa.ctrl_mem, 2'b10);
    chk("hz1_release", flags(), 3'b110);
    push_ex(8'h21, 5'd3); tick();
    chk("lw_ctrl_wb", ifa.ctrl_wb, 3'b110);
    chk("lw_dest_wb", ifa.dest_wb, 5'd31);

    // Branches
    set_id(6'h04, 6'h00, 5'd1, 5'd1, 5'd0, 1'b1);
    chk("beq_flags", flags(), 3'b111);
    chk("beq_code", ifa.compare_code_id, 2'd1);
    chk("beq_src", ifa.branch_src_id, 2'd0);
    push_ex(8'h00, 5'd0); tick();
    set_id(6'h05, 6'h00, 5'd1, 5'd1, 5'd0, 1'b1);
    chk("bne_flags", flags(), 3'b110);
    chk("bne_code", ifa.compare_code_id, 2'd2);
    push_ex(8'h00, 5'd0); tick();

    // JAL with rd field 31 (RegDest 0 selects rd), through to WB
    set_id(6'h03, 6'h00, 5'd0, 5'd0, 5'd31, 1'b0);
    chk("jal_flags", flags(), 3'b111);
    chk("jal_src", ifa.branch_src_id, 2'd1);
    chk("jal_code", ifa.compare_code_id, 2'd3);
    push_ex(8'h85, 5'd31); tick();
    set_id(6'h00, 6'h08, 5'd8, 5'd0, 5'd0, 1'b0);  // JR
    chk("jr_src", ifa.branch_src_id, 2'd2);
    chk("jr_flush", ifa.ifid_flush, 1'b1);
    push_ex(8'h00, 5'd0); tick();
    chk("jal_ctrl_mem", ifa.ctrl_mem, 2'b00);
    set_id(6'h08, 6'h00, 5'd1, 5'd7, 5'd0, 1'b0);  // ADDI -> rt
    push_ex(8'h22, 5'd7); tick();
    chk("jal_ctrl_wb", ifa.ctrl_wb, 3'b101);
    chk("jal_dest_wb", ifa.dest_wb, 5'd31);
    set_id(6'h2B, 6'h00, 5'd1, 5'd2, 5'd9, 1'b0);  // SW -> rd
    push_ex(8'h88, 5'd9); tick();
    set_id(6'h00, 6'h21, 5'd1, 5'd0, 5'd9, 1'b0);  // R-type to $0
    push_ex(8'h21, 5'd0); tick();
    set_id(6'h11, 6'h00, 5'd1, 5'd2, 5'd3, 1'b1);  // unknown opcode
    chk("unk_flags", flags(), 3'b110);
    push_ex(8'h00, 5'd3); tick();

    // LW then unrelated registers: no stall
    set_id(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    push_ex(8'hD6, 5'd31); tick();
    set_id(6'h2B, 6'h00, 5'd5, 5'd6, 5'd0, 1'b0);
    chk("nohz_flags", flags(), 3'b110);
    push_ex(8'h88, 5'd0); tick();

    // LW then taken BEQ depending via rt: stall wins, flush after release
    set_id(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    push_ex(8'hD6, 5'd31); tick();
    set_id(6'h04, 6'h00, 5'd5, 5'd31, 5'd0, 1'b1);
    chk("hzbr_stall", flags(), 3'b000);
    push_ex(8'h00, 5'd0); tick();
    chk("hzbr_flush", flags(), 3'b111);
    push_ex(8'h00, 5'd0); tick();

    // LOAD_STALL=3 instance, RA_REG=2
    sel = 1'b1;
    set_id(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    push_ex(8'hD6, 5'd2); tick();
    set_id(6'h00, 6'h20, 5'd2, 5'd3, 5'd4, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("hz3_stall", flags(), 3'b000);
      push_ex(8'h00, 5'd0); tick();
    end
    chk("hz3_release", flags(), 3'b110);
    push_ex(8'h21, 5'd3); tick();

    // Reset in the middle of a stall
    set_id(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    push_ex(8'hD6, 5'd2); tick();
    set_id(6'h00, 6'h20, 5'd2, 5'd3, 5'd4, 1'b0);
    chk("rs_stall", flags(), 3'b000);
    push_ex(8'h00, 5'd0); tick();
    rst = 1'b1; #1;
    chk("rs_flags", flags(), 3'b000);
    push_ex(8'h00, 5'd0); tick();
    chk("rs_ctrl_mem", ifb.ctrl_mem, 2'b00);
    chk("rs_ctrl_wb", ifb.ctrl_wb, 3'b000);
    chk("rs_dest_mem", ifb.dest_mem, 5'd0);
    rst = 1'b0; #1;
    chk("rs_resume", flags(), 3'b110);
    push_ex(8'h21, 5'd3); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
